// File: rtl/mul_8bit_seq_pkg.sv
// Shared definitions for the sequential 8x8 multiplier: FSM state encoding,
// the order in which nibble pairs are multiplied, and the weight of each step.
package mul_8bit_seq_pkg;

    // Operand and product widths are fixed by the datapath.
    localparam int OPERAND_W = 8;
    localparam int NIBBLE_W  = 4;
    localparam int PARTIAL_W = 8;
    localparam int PRODUCT_W = 16;

    // Controller states.
    // IDLE waits for an operand pair.
    // MUL runs the four partial-product steps.
    // DONE holds the finished product for the consumer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Step numbering.
    // L = low nibble, H = high nibble.
    // The first letter names the nibble of operand a, the second the nibble of operand b.
    localparam logic [1:0] STEP_LL = 2'd0;
    localparam logic [1:0] STEP_LH = 2'd1;
    localparam logic [1:0] STEP_HL = 2'd2;
    localparam logic [1:0] STEP_HH = 2'd3;

    // The last step of the sequence. The controller leaves MUL after it.
    localparam logic [1:0] STEP_LAST = STEP_HH;

    // Left shift that gives each partial product its weight in the result.
    localparam logic [3:0] SHIFT_LL = 4'd0;
    localparam logic [3:0] SHIFT_LH = 4'd4;
    localparam logic [3:0] SHIFT_HL = 4'd4;
    localparam logic [3:0] SHIFT_HH = 4'd8;

    // Map a step number to its shift amount.
    function automatic logic [3:0] stepShift(input logic [1:0] step);
        logic [3:0] shiftAmt;
        case (step)
            STEP_LL: shiftAmt = SHIFT_LL;
            STEP_LH: shiftAmt = SHIFT_LH;
            STEP_HL: shiftAmt = SHIFT_HL;
            default: shiftAmt = SHIFT_HH;
        endcase
        return shiftAmt;
    endfunction

endpackage

// File: rtl/mul_8bit_seq_mul_4bit.sv
// Combinational 4x4 unsigned multiplier.
// It is the only multiply resource in the sequential multiplier and is reused on every step.
module mul_4bit
    import mul_8bit_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0]  a_i,
    input  logic [NIBBLE_W-1:0]  b_i,
    output logic [PARTIAL_W-1:0] product_o
);

    // A 4x4 product always fits in 8 bits, so no bits are lost.
    always_comb begin
        product_o = PARTIAL_W'(a_i) * PARTIAL_W'(b_i);
    end

endmodule

// File: rtl/mul_8bit_seq.sv
// Sequential 8x8 unsigned multiplier.
// One 4x4 multiplier is reused over four steps.
// Each step adds one shifted nibble product into a 16-bit accumulator.
// The result is held in DONE until the consumer takes it.
module mul_8bit_seq
    import mul_8bit_seq_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_valid_i,
    output logic                 ready_o,
    input  logic [OPERAND_W-1:0] operand_a_i,
    input  logic [OPERAND_W-1:0] operand_b_i,
    input  logic                 clear_i,
    output logic [PRODUCT_W-1:0] result_o,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic                 busy_o
);

    // Controller state.
    mul_state_e state_q;
    mul_state_e state_d;

    // Operand registers.
    // They are loaded on accept and stay fixed for the whole operation.
    logic [OPERAND_W-1:0] opA_q;
    logic [OPERAND_W-1:0] opA_d;
    logic [OPERAND_W-1:0] opB_q;
    logic [OPERAND_W-1:0] opB_d;

    // Running sum of the shifted partial products.
    logic [PRODUCT_W-1:0] accum_q;
    logic [PRODUCT_W-1:0] accum_d;

    // Step counter. It selects the nibble pair and the shift.
    logic [1:0] step_q;
    logic [1:0] step_d;

    // Datapath between the nibble mux, the multiplier and the accumulator.
    logic [NIBBLE_W-1:0]  nibbleA;
    logic [NIBBLE_W-1:0]  nibbleB;
    logic [PARTIAL_W-1:0] partial;
    logic [PRODUCT_W-1:0] partialAligned;
    logic                 accept;

    // Handshake on the request side. A request is taken only while idle.
    assign accept = start_valid_i && (state_q == IDLE);

    // Pick the nibble pair that the current step multiplies.
    always_comb begin
        nibbleA = opA_q[3:0];
        nibbleB = opB_q[3:0];
        case (step_q)
            STEP_LL: begin
                nibbleA = opA_q[3:0];
                nibbleB = opB_q[3:0];
            end
            STEP_LH: begin
                nibbleA = opA_q[3:0];
                nibbleB = opB_q[7:4];
            end
            STEP_HL: begin
                nibbleA = opA_q[7:4];
                nibbleB = opB_q[3:0];
            end
            default: begin
                nibbleA = opA_q[7:4];
                nibbleB = opB_q[7:4];
            end
        endcase
    end

    // The single shared 4x4 multiplier.
    mul_4bit u_mul_4bit (
        .a_i       (nibbleA),
        .b_i       (nibbleB),
        .product_o (partial)
    );

    // Zero-extend the partial product and shift it to the weight of the current step.
    always_comb begin
        partialAligned = {8'h00, partial} << stepShift(step_q);
    end

    // Next-state logic for the controller and the datapath registers.
    // A clear wins over everything else, including a same-cycle accept or result handoff.
    always_comb begin
        state_d = state_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        accum_d = accum_q;
        step_d  = step_q;

        if (clear_i) begin
            state_d = IDLE;
            accum_d = '0;
            step_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        opA_d   = operand_a_i;
                        opB_d   = operand_b_i;
                        accum_d = '0;
                        step_d  = '0;
                        state_d = MUL;
                    end
                end
                MUL: begin
                    // The carry-out is dropped. An 8x8 product never exceeds 16 bits.
                    accum_d = accum_q + partialAligned;
                    if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        state_d = DONE;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
                DONE: begin
                    if (result_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    accum_d = '0;
                    step_d  = '0;
                end
            endcase
        end
    end

    // State and datapath registers.
    // Reset discards any operation in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            accum_q <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            accum_q <= accum_d;
            step_q  <= step_d;
        end
    end

    // Outputs are decoded directly from the registered state.
    // result_o always shows the accumulator, so it is predictable outside DONE too.
    assign ready_o        = (state_q == IDLE);
    assign busy_o         = (state_q == MUL);
    assign result_valid_o = (state_q == DONE);
    assign result_o       = accum_q;

endmodule

// File: tb/tb_mul_8bit_seq.sv
// Self-checking bench for mul_8bit_seq.
// A transaction-level model predicts the handshake outputs and the product.
// Directed vectors pin exact literal products and the latency.
module tb_mul_8bit_seq;

    logic        clk_i;
    logic        rst_ni;
    logic        start_valid_i;
    logic        ready_o;
    logic [7:0]  operand_a_i;
    logic [7:0]  operand_b_i;
    logic        clear_i;
    logic [15:0] result_o;
    logic        result_valid_o;
    logic        result_ready_i;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    // Value that result_ready_i returns to after each handoff.
    bit holdReady = 1'b0;

    // The compare process starts once the model has seen reset.
    bit modelOn = 1'b0;

    // Model state.
    bit          mIdle;
    int          mLeft;
    bit          mHold;
    logic [15:0] mProduct;

    mul_8bit_seq dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_valid_i  (start_valid_i),
        .ready_o        (ready_o),
        .operand_a_i    (operand_a_i),
        .operand_b_i    (operand_b_i),
        .clear_i        (clear_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .busy_o         (busy_o)
    );

    // 10-time-unit clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Transaction model.
    // An accepted pair yields a*b after four cycles of work.
    // The product is then held until the consumer takes it.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mIdle    <= 1'b1;
            mLeft    <= 0;
            mHold    <= 1'b0;
            mProduct <= 16'h0000;
        end else if (clear_i) begin
            mIdle <= 1'b1;
            mLeft <= 0;
            mHold <= 1'b0;
        end else if (mIdle) begin
            if (start_valid_i) begin
                mIdle    <= 1'b0;
                mLeft    <= 4;
                mProduct <= {8'h00, operand_a_i} * {8'h00, operand_b_i};
            end
        end else if (mLeft > 0) begin
            mLeft <= mLeft - 1;
            if (mLeft == 1) mHold <= 1'b1;
        end else if (mHold && result_ready_i) begin
            mHold <= 1'b0;
            mIdle <= 1'b1;
        end
    end

    // One comparison: count it, and report it if it fails.
    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Check the DUT against the model on every falling edge.
    always @(negedge clk_i) begin
        if (modelOn) begin
            checkOutput("cmp ready_o", 16'(ready_o), 16'(mIdle));
            checkOutput("cmp busy_o", 16'(busy_o), 16'(mLeft > 0));
            checkOutput("cmp result_valid_o", 16'(result_valid_o), 16'(mHold));
            if (mHold) checkOutput("cmp result_o", result_o, mProduct);
        end
    end

    // Wait for ready_o (bounded), then present one operand pair for one cycle.
    // The operands are scrambled after the accepting edge, so a design that
    // keeps sampling them after accept produces a wrong product.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        int guard = 0;
        while (!ready_o && guard < 50) begin
            @(posedge clk_i);
            #1;
            guard++;
        end
        checkOutput("ready before start", 16'(ready_o), 16'h0001);
        start_valid_i = 1'b1;
        operand_a_i   = a;
        operand_b_i   = b;
        @(posedge clk_i);
        #1;
        start_valid_i = 1'b0;
        operand_a_i   = 8'($urandom);
        operand_b_i   = 8'($urandom);
    endtask

    // Count the edges after the accepting edge until result_valid_o is seen.
    task automatic waitResult();
        int latency = 0;
        while (!result_valid_o && latency < 20) begin
            @(posedge clk_i);
            #1;
            latency++;
        end
        checkOutput("latency", 16'(latency), 16'd4);
    endtask

    // Hand the result to the consumer. The block must be ready on the next cycle.
    task automatic consumeResult();
        result_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        result_ready_i = holdReady;
        checkOutput("ready after consume", 16'(ready_o), 16'h0001);
        checkOutput("valid after consume", 16'(result_valid_o), 16'h0000);
    endtask

    // One complete operation: start it, wait for it, check the product, hand it off.
    task automatic runOp(input string name, input logic [7:0] a, input logic [7:0] b, input logic [15:0] expected);
        applyStimulus(a, b);
        waitResult();
        checkOutput(name, result_o, expected);
        consumeResult();
    endtask

    // Check that every output is at its reset value.
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " ready_o"}, 16'(ready_o), 16'h0001);
        checkOutput({tag, " result_valid_o"}, 16'(result_valid_o), 16'h0000);
        checkOutput({tag, " busy_o"}, 16'(busy_o), 16'h0000);
        checkOutput({tag, " result_o"}, result_o, 16'h0000);
    endtask

    // Release reset, then confirm that no stale result appears.
    task automatic releaseAndQuiet(input string tag);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (8) begin
            @(posedge clk_i);
            #1;
            checkOutput({tag, " no valid after reset"}, 16'(result_valid_o), 16'h0000);
        end
    endtask

    // Stop a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [15:0] rexp;

        rst_ni         = 1'b0;
        start_valid_i  = 1'b0;
        operand_a_i    = 8'h00;
        operand_b_i    = 8'h00;
        clear_i        = 1'b0;
        result_ready_i = 1'b0;

        // Outputs while reset is held.
        repeat (2) @(posedge clk_i);
        #1;
        checkResetOutputs("reset");
        modelOn = 1'b1;
        rst_ni  = 1'b1;
        @(posedge clk_i);
        #1;

        // 0xFF * 0xFF with the consumer always ready.
        holdReady      = 1'b1;
        result_ready_i = 1'b1;
        runOp("FFxFF", 8'hFF, 8'hFF, 16'hFE01);
        checkOutput("model pin FFxFF", mProduct, 16'hFE01);

        // Basic products with the consumer handing off explicitly.
        holdReady      = 1'b0;
        result_ready_i = 1'b0;
        runOp("12x34", 8'h12, 8'h34, 16'h03A8);
        checkOutput("model pin 12x34", mProduct, 16'h03A8);
        runOp("00xAB", 8'h00, 8'hAB, 16'h0000);

        // Backpressure: the result is held for 10 cycles while a new start is offered.
        applyStimulus(8'h5A, 8'h3C);
        waitResult();
        start_valid_i = 1'b1;
        operand_a_i   = 8'h11;
        operand_b_i   = 8'h22;
        repeat (10) begin
            @(posedge clk_i);
            #1;
            checkOutput("bp result_o", result_o, 16'h1518);
            checkOutput("bp valid", 16'(result_valid_o), 16'h0001);
            checkOutput("bp ready_o", 16'(ready_o), 16'h0000);
        end
        start_valid_i = 1'b0;
        consumeResult();

        // Clear at step 2 aborts the operation.
        applyStimulus(8'hC3, 8'h7E);
        repeat (2) begin
            @(posedge clk_i);
            #1;
        end
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        checkOutput("clear ready_o", 16'(ready_o), 16'h0001);
        checkOutput("clear busy_o", 16'(busy_o), 16'h0000);
        checkOutput("clear result_o", result_o, 16'h0000);
        repeat (6) begin
            @(posedge clk_i);
            #1;
            checkOutput("clear no valid", 16'(result_valid_o), 16'h0000);
        end
        runOp("0Fx10", 8'h0F, 8'h10, 16'h00F0);

        // Clear and start in the same idle cycle: clear wins and nothing starts.
        clear_i       = 1'b1;
        start_valid_i = 1'b1;
        operand_a_i   = 8'h21;
        operand_b_i   = 8'h43;
        @(posedge clk_i);
        #1;
        clear_i       = 1'b0;
        start_valid_i = 1'b0;
        checkOutput("clear prio ready_o", 16'(ready_o), 16'h0001);
        checkOutput("clear prio busy_o", 16'(busy_o), 16'h0000);

        // Reset while MUL is in progress.
        applyStimulus(8'hAA, 8'h55);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        checkResetOutputs("rst in MUL");
        releaseAndQuiet("rst in MUL");
        runOp("80x02 after MUL rst", 8'h80, 8'h02, 16'h0100);

        // Reset while the result is held in DONE.
        applyStimulus(8'h33, 8'h44);
        waitResult();
        #1;
        rst_ni = 1'b0;
        #1;
        checkResetOutputs("rst in DONE");
        releaseAndQuiet("rst in DONE");
        runOp("80x02 after DONE rst", 8'h80, 8'h02, 16'h0100);

        // Random operand pairs, alternating always-ready and explicit handoff.
        for (int i = 0; i < 1000; i++) begin
            holdReady      = i[0];
            result_ready_i = holdReady;
            ra             = 8'($urandom);
            rb             = 8'($urandom);
            rexp           = 16'(int'(ra) * int'(rb));
            runOp("random", ra, rb, rexp);
        end
        result_ready_i = 1'b0;

        repeat (2) @(posedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
